// File: rtl/btn_conditioner_if.sv
// Bus between the raw pushbutton pins and the conditioner outputs that feed
// the game core. The master drives the pins and the ms scale; the slave is the
// conditioner.
interface btn_conditioner_if #(
    parameter int NUM_BTN = 4,
    parameter int CODE_W  = 2
);
    logic [15:0]         ticks_per_milli;
    logic [NUM_BTN-1:0]  btn_raw;
    logic [NUM_BTN-1:0]  btn;
    logic [NUM_BTN-1:0]  pressed;
    logic [NUM_BTN-1:0]  released;
    logic                any_down;
    logic                press_valid;
    logic [CODE_W-1:0]   press_code;
    logic [1:0]          rand_out;

    modport master (
        output ticks_per_milli, btn_raw,
        input  btn, pressed, released, any_down, press_valid, press_code, rand_out
    );

    modport slave (
        input  ticks_per_milli, btn_raw,
        output btn, pressed, released, any_down, press_valid, press_code, rand_out
    );
endinterface

// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: 2-flop sync, per-button ms debounce, edge pulses and
// one-hot press decode for the game core.
// Optional macro BTN_ENTROPY_EN: adds a 16-bit LFSR perturbed by press timing,
// exposed on rand_out; without it rand_out is tied to 0.
module btn_conditioner #(
    parameter int NUM_BTN     = 4,
    parameter int DEBOUNCE_MS = 10,
    parameter int CODE_W      = 2
) (
    input  logic               clk,
    input  logic               rst,
    btn_conditioner_if.slave   bus
);
    localparam int MS_W = (DEBOUNCE_MS < 2) ? 1 : $clog2(DEBOUNCE_MS + 1);

    typedef enum logic {ST_STABLE, ST_COUNTING} db_state_t;

    logic [NUM_BTN-1:0] r_s1, r_s2;
    logic [NUM_BTN-1:0] r_btn, r_pressed, r_released;
    logic [NUM_BTN-1:0] w_commit;
    logic [15:0]        r_tick_cnt;
    logic               w_milli_tick;
    logic               w_press_valid;
    logic [CODE_W-1:0]  w_press_code;

    // Two-flop synchroniser on the asynchronous pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= bus.btn_raw;
            r_s2 <= r_s1;
        end
    end

    // ms tick: >= rather than == so lowering ticks_per_milli at runtime can't
    // strand the counter above the wrap point; 0 and 1 both tick every cycle.
    always_comb begin
        w_milli_tick = (bus.ticks_per_milli <= 16'd1) ||
                       (r_tick_cnt >= (bus.ticks_per_milli - 16'd1));
    end

    // Free-running tick counter, wrapping on each ms tick.
    always_ff @(posedge clk) begin
        if (rst)               r_tick_cnt <= '0;
        else if (w_milli_tick) r_tick_cnt <= '0;
        else                   r_tick_cnt <= r_tick_cnt + 16'd1;
    end

    generate
        if (DEBOUNCE_MS == 0) begin : g_nodb
            assign w_commit = r_s2 ^ r_btn;
        end else begin : g_db
            for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
                db_state_t        r_state, w_state_nxt;
                logic [MS_W-1:0]  r_ms_cnt, w_ms_cnt_nxt, w_base;
                logic             w_diff, w_cm;

                // Debounce FSM next state. The first mismatched cycle already
                // counts, so with a tick every cycle the level commits
                // DEBOUNCE_MS cycles after the synchroniser shows it.
                always_comb begin
                    w_state_nxt  = r_state;
                    w_ms_cnt_nxt = r_ms_cnt;
                    w_cm         = 1'b0;
                    w_diff       = r_s2[g] ^ r_btn[g];
                    w_base       = '0;
                    case (r_state)
                        ST_STABLE:   w_base = '0;
                        ST_COUNTING: w_base = r_ms_cnt;
                        default:     w_base = '0;
                    endcase
                    if (!w_diff) begin
                        // level matches (or glitch vanished): drop any count
                        w_state_nxt  = ST_STABLE;
                        w_ms_cnt_nxt = '0;
                    end else begin
                        w_state_nxt  = ST_COUNTING;
                        w_ms_cnt_nxt = w_base;
                        if (w_milli_tick) begin
                            if (w_base == MS_W'(DEBOUNCE_MS - 1)) begin
                                w_cm         = 1'b1;
                                w_state_nxt  = ST_STABLE;
                                w_ms_cnt_nxt = '0;
                            end else begin
                                w_ms_cnt_nxt = w_base + 1'b1;
                            end
                        end
                    end
                end

                // Debounce FSM state and ms counter.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_state  <= ST_STABLE;
                        r_ms_cnt <= '0;
                    end else begin
                        r_state  <= w_state_nxt;
                        r_ms_cnt <= w_ms_cnt_nxt;
                    end
                end

                assign w_commit[g] = w_cm;
            end
        end
    endgenerate

    // Accepted level plus press/release pulses, registered together so the
    // pulse lines up with the cycle btn shows its new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn      <= '0;
            r_pressed  <= '0;
            r_released <= '0;
        end else begin
            r_btn      <= r_btn ^ w_commit;
            r_pressed  <= w_commit & r_s2;
            r_released <= w_commit & ~r_s2;
        end
    end

    // Press decode: only an unambiguous single press with nothing else held.
    always_comb begin
        w_press_valid = $onehot(r_pressed) && $onehot(r_btn);
        w_press_code  = '0;
        if (w_press_valid) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (r_pressed[i]) w_press_code = CODE_W'(i);
            end
        end
    end

    assign bus.btn         = r_btn;
    assign bus.pressed     = r_pressed;
    assign bus.released    = r_released;
    assign bus.any_down    = |r_btn;
    assign bus.press_valid = w_press_valid;
    assign bus.press_code  = w_press_code;

`ifdef BTN_ENTROPY_EN
    logic [15:0] r_lfsr, w_lfsr_step, w_lfsr_nxt;

    // Galois step (x^16+x^14+x^13+x^11+1), then fold in press timing.
    always_comb begin
        w_lfsr_step = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        w_lfsr_nxt  = w_lfsr_step;
        if (|r_pressed) w_lfsr_nxt[7:0] = w_lfsr_step[7:0] ^ r_tick_cnt[7:0];
    end

    // Entropy register.
    always_ff @(posedge clk) begin
        if (rst) r_lfsr <= 16'hACE1;
        else     r_lfsr <= w_lfsr_nxt;
    end

    assign bus.rand_out = r_lfsr[1:0];
`else
    assign bus.rand_out = 2'b00;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner (NUM_BTN=4, DEBOUNCE_MS=10).
module tb_btn_conditioner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    btn_conditioner_if #(.NUM_BTN(4), .CODE_W(2)) u_if ();

    btn_conditioner #(.NUM_BTN(4), .DEBOUNCE_MS(10), .CODE_W(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, act, exp);
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_btn"}, u_if.btn, 4'b0000);
        chk({tag, "_prs"}, u_if.pressed, 4'b0000);
        chk({tag, "_rel"}, u_if.released, 4'b0000);
        chk({tag, "_any"}, u_if.any_down, 1'b0);
        chk({tag, "_pv"},  u_if.press_valid, 1'b0);
        chk({tag, "_pc"},  u_if.press_code, 2'd0);
    endtask

    int cnt, acc, acc_pv;

    initial begin
        u_if.ticks_per_milli = 16'd1;
        u_if.btn_raw         = 4'b1011;
        rst = 1'b1;
        wait_n(3);
        chk_idle("rst");
        chk("rst_rand", u_if.rand_out, 2'b00);
        u_if.btn_raw = 4'b0000;
        rst = 1'b0;
        wait_n(4);

        // 1: clean press of button 1
        u_if.btn_raw = 4'b0010;
        wait_n(11);
        chk("t1_btn_early", u_if.btn, 4'b0000);
        wait_n(1);
        chk("t1_btn",  u_if.btn, 4'b0010);
        chk("t1_prs",  u_if.pressed, 4'b0010);
        chk("t1_pv",   u_if.press_valid, 1'b1);
        chk("t1_pc",   u_if.press_code, 2'd1);
        chk("t1_any",  u_if.any_down, 1'b1);
        wait_n(1);
        chk("t1_prs_off", u_if.pressed, 4'b0000);
        chk("t1_pv_off",  u_if.press_valid, 1'b0);
        chk("t1_pc_off",  u_if.press_code, 2'd0);
        chk("t1_hold",    u_if.btn, 4'b0010);
        u_if.btn_raw = 4'b0000;
        wait_n(11);
        chk("t1_rel_early", u_if.btn, 4'b0010);
        wait_n(1);
        chk("t1_rel_btn", u_if.btn, 4'b0000);
        chk("t1_rel",     u_if.released, 4'b0010);
        chk("t1_rel_pv",  u_if.press_valid, 1'b0);
        wait_n(3);

        // 2: bounce on button 0: 9 high, 1 low, then steady high
        acc = 0;
        u_if.btn_raw = 4'b0001;
        for (int i = 0; i < 9; i++) begin @(negedge clk); acc += int'(u_if.pressed[0]); end
        u_if.btn_raw = 4'b0000;
        @(negedge clk); acc += int'(u_if.pressed[0]);
        u_if.btn_raw = 4'b0001;
        for (int i = 0; i < 11; i++) begin @(negedge clk); acc += int'(u_if.pressed[0]); end
        chk("t2_btn_early", u_if.btn[0], 1'b0);
        @(negedge clk); acc += int'(u_if.pressed[0]);
        chk("t2_btn", u_if.btn[0], 1'b1);
        for (int i = 0; i < 4; i++) begin @(negedge clk); acc += int'(u_if.pressed[0]); end
        chk("t2_pulses", acc, 1);
        u_if.btn_raw = 4'b0000;
        wait_n(16);

        // 3: simultaneous press, then a third button while two are held
        u_if.btn_raw = 4'b0101;
        wait_n(12);
        chk("t3_btn", u_if.btn, 4'b0101);
        chk("t3_prs", u_if.pressed, 4'b0101);
        chk("t3_pv",  u_if.press_valid, 1'b0);
        chk("t3_pc",  u_if.press_code, 2'd0);
        wait_n(2);
        u_if.btn_raw = 4'b0111;
        wait_n(12);
        chk("t3b_btn", u_if.btn, 4'b0111);
        chk("t3b_prs", u_if.pressed, 4'b0010);
        chk("t3b_pv",  u_if.press_valid, 1'b0);
        u_if.btn_raw = 4'b0000;
        wait_n(16);
        chk_idle("t3_end");

        // 4: ms timing with 50 clocks/ms on button 3
        u_if.ticks_per_milli = 16'd50;
        u_if.btn_raw = 4'b1000;
        for (int k = 0; k < 700; k++) begin @(negedge clk); if (u_if.btn[3]) break; end
        chk("t4_press_seen", u_if.btn[3], 1'b1);
        wait_n(20);
        u_if.btn_raw = 4'b0000;
        cnt = 0; acc = 0; acc_pv = 0;
        for (int k = 0; k < 700; k++) begin
            @(negedge clk);
            cnt++;
            acc    += int'(u_if.released[3]);
            acc_pv += int'(u_if.press_valid);
            if (!u_if.btn[3]) break;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            acc    += int'(u_if.released[3]);
            acc_pv += int'(u_if.press_valid);
        end
        chk("t4_fell",   u_if.btn[3], 1'b0);
        chk("t4_window", (cnt >= 451 && cnt <= 551), 1'b1);
        chk("t4_relcnt", acc, 1);
        chk("t4_pv",     acc_pv, 0);

        // 5: reset in the middle of a debounce discards the partial count
        u_if.ticks_per_milli = 16'd1;
        wait_n(2);
        u_if.btn_raw = 4'b0001;
        wait_n(6);
        rst = 1'b1;
        wait_n(1);
        chk_idle("t5_rst");
        rst = 1'b0;
        wait_n(11);
        chk("t5_btn_early", u_if.btn[0], 1'b0);
        wait_n(1);
        chk("t5_btn", u_if.btn[0], 1'b1);
        chk("t5_pv",  u_if.press_valid, 1'b1);
        chk("t5_pc",  u_if.press_code, 2'd0);
        u_if.btn_raw = 4'b0000;
        wait_n(16);

`ifdef BTN_ENTROPY_EN
        begin
            logic [15:0] m;
            rst = 1'b1;
            wait_n(2);
            rst = 1'b0;
            m = 16'hACE1;
            chk("t6_seed", u_if.rand_out, m[1:0]);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                m = {1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0000);
                chk("t6_lfsr", u_if.rand_out, m[1:0]);
            end
        end
`else
        acc = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); acc += int'(u_if.rand_out); end
        chk("t6_rand_zero", acc, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
